// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: sequential double-dabble binary-to-BCD
// conversion, atomic display commit, leading-zero blanking and digit scanning.
module display_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int DATA_W      = 14,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_W-1:0]     valor,
   output logic                  busy,
   output logic                  overflow,
   output logic [3:0]            digito,
   output logic [NUM_DIGITS-1:0] anodos
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CW    = $clog2(DATA_W);
   localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(10 ** NUM_DIGITS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_W-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic [BCD_W-1:0]      disp_q, disp_d;
   logic                  ovf_q, ovf_d;
   logic [RW-1:0]         ref_q, ref_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BCD_W-1:0]      adj;
   logic [NUM_DIGITS-1:0] blank;

   // Conversion datapath: add-3 correction on every nibble, then shift {bcd, bin}.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      adj     = bcd_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d   = valor;
               bcd_d   = '0;
               cnt_d   = '0;
               pend_d  = (valor > MAX_VAL);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
            bin_d = {bin_q[DATA_W-2:0], 1'b0};
            if (cnt_q == CW'(DATA_W - 1)) begin
               state_d = S_COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_COMMIT: begin
            disp_d  = bcd_q;
            ovf_d   = pend_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
      end
   end

   // A digit is blank when it and every more-significant nibble are zero.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_lsd
            assign blank[gi] = ovf_q;
         end else begin : g_upper
            assign blank[gi] = ovf_q | ~|disp_q[BCD_W-1:4*gi];
         end
      end
   endgenerate

   always_comb begin
      digito = 4'hF;
      anodos = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            anodos[k] = 1'b0;
            digito    = blank[k] ? 4'hF : disp_q[4*k +: 4];
         end
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random
// load/reset traffic compared against an arithmetic reference model.
module tb_display_scan_ctrl;
   localparam int ND = 4;
   localparam int DW = 14;
   localparam int RD = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load  = 1'b0;
   logic [DW-1:0] valor = '0;
   logic          busy;
   logic          overflow;
   logic [3:0]    digito;
   logic [ND-1:0] anodos;

   int tests_run    = 0;
   int tests_failed = 0;

   display_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .valor    (valor),
      .busy     (busy),
      .overflow (overflow),
      .digito   (digito),
      .anodos   (anodos)
   );

   always #5 clock = ~clock;

   // Reference model: edges since reset, a busy countdown and the committed value.
   int ncyc   = 0;
   int m_left = 0;
   int m_pend = 0;
   int m_val  = 0;
   bit m_ovf  = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         ncyc   <= 0;
         m_left <= 0;
         m_val  <= 0;
         m_ovf  <= 1'b0;
      end else begin
         ncyc <= ncyc + 1;
         if (m_left == 0) begin
            if (load) begin
               m_left <= DW + 1;
               m_pend <= int'(valor);
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_val <= m_pend;
               m_ovf <= (m_pend > 9999);
            end
         end
      end
   end

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [3:0] exp_digito();
      int k = (ncyc / RD) % ND;
      if (m_ovf) return 4'hF;
      if (k > 0 && m_val < pow10(k)) return 4'hF;
      return 4'((m_val / pow10(k)) % 10);
   endfunction

   function automatic logic [ND-1:0] exp_anodos();
      int k = (ncyc / RD) % ND;
      return ~(ND'(1) << k);
   endfunction

   function automatic logic [ND+5:0] exp_outs();
      return {(m_left != 0), m_ovf, exp_anodos(), exp_digito()};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_value(input int v);
      load  = 1'b1;
      valor = DW'(v);
      step();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load  = 1'b0;
      step();
      step();
      tests_run++;
      if ({busy, overflow, anodos, digito} !== {1'b0, 1'b0, 4'b1110, 4'h0}) begin
         tests_failed++;
         $display("FAIL reset_state: {busy,ovf,an,dig}=%b required %b",
                  {busy, overflow, anodos, digito}, {1'b0, 1'b0, 4'b1110, 4'h0});
      end
      reset = 1'b0;
      repeat (4) begin
         step();
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL reset_scan: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
      end
      tests_run++;
      if ({anodos, digito} !== {4'b1101, 4'hF}) begin
         tests_failed++;
         $display("FAIL reset_index1: {an,dig}=%b required %b", {anodos, digito}, {4'b1101, 4'hF});
      end
   endtask

   task automatic test_busy_and_scan();
      logic [3:0] tbl [4];
      int n = 1;
      int guard = 0;
      tbl[0] = 4'd4; tbl[1] = 4'd3; tbl[2] = 4'd2; tbl[3] = 4'd1;
      load_value(1234);
      while (busy && guard < 40) begin
         step();
         guard++;
         if (busy) n++;
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL conv_1234: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
      end
      tests_run++;
      if (n != 15) begin
         tests_failed++;
         $display("FAIL busy_length: busy cycles=%0d required 15", n);
      end
      repeat (20) begin
         step();
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL scan_1234: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
         for (int k = 0; k < ND; k++) begin
            if (anodos == ~(ND'(1) << k)) begin
               tests_run++;
               if (digito !== tbl[k]) begin
                  tests_failed++;
                  $display("FAIL scan_digit%0d: digito=%h required %h", k, digito, tbl[k]);
               end
            end
         end
      end
   endtask

   task automatic test_blanking();
      int vals [3];
      vals[0] = 7; vals[1] = 1000; vals[2] = 0;
      for (int i = 0; i < 3; i++) begin
         load_value(vals[i]);
         repeat (40) begin
            step();
            tests_run++;
            if ({busy, overflow, anodos, digito} !== exp_outs()) begin
               tests_failed++;
               $display("FAIL blank_%0d: got %b required %b", vals[i],
                        {busy, overflow, anodos, digito}, exp_outs());
            end
         end
      end
   endtask

   task automatic test_overflow();
      int vals [2];
      bit want [2];
      vals[0] = 10000; vals[1] = 9999;
      want[0] = 1'b1;  want[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_value(vals[i]);
         repeat (36) begin
            step();
            tests_run++;
            if ({busy, overflow, anodos, digito} !== exp_outs()) begin
               tests_failed++;
               $display("FAIL ovf_%0d: got %b required %b", vals[i],
                        {busy, overflow, anodos, digito}, exp_outs());
            end
         end
         tests_run++;
         if (overflow !== want[i]) begin
            tests_failed++;
            $display("FAIL ovf_flag_%0d: overflow=%b required %b", vals[i], overflow, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 1;
      load_value(1234);
      repeat (3) step();
      load  = 1'b1;
      valor = DW'(5678);
      step();
      load  = 1'b0;
      n = 5;
      repeat (30) begin
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL b2b: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
         step();
         if (busy) n++;
      end
      tests_run++;
      if (n != 15) begin
         tests_failed++;
         $display("FAIL b2b_busy_length: busy cycles=%0d required 15", n);
      end
      tests_run++;
      if (m_val != 1234 || (anodos == 4'b1110 && digito !== 4'd4)) begin
         tests_failed++;
         $display("FAIL b2b_value: model=%0d digito=%h (an %b) required 1234", m_val, digito, anodos);
      end
   endtask

   task automatic test_reset_mid();
      load_value(4321);
      repeat (20) begin
         step();
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL pre_abort: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
      end
      load_value(56);
      repeat (7) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests_run++;
      if ({busy, overflow, anodos, digito} !== {1'b0, 1'b0, 4'b1110, 4'h0}) begin
         tests_failed++;
         $display("FAIL abort_state: {busy,ovf,an,dig}=%b required %b",
                  {busy, overflow, anodos, digito}, {1'b0, 1'b0, 4'b1110, 4'h0});
      end
      repeat (24) begin
         step();
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL post_abort: got %b required %b", {busy, overflow, anodos, digito}, exp_outs());
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         load  = ($urandom_range(0, 9) == 0);
         valor = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 16383))
                                             : DW'($urandom_range(0, 9999));
         reset = ($urandom_range(0, 199) == 0);
         step();
         tests_run++;
         if ({busy, overflow, anodos, digito} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL random c%0d: got %b required %b (model val %0d)", c,
                     {busy, overflow, anodos, digito}, exp_outs(), m_val);
         end
      end
      load  = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_busy_and_scan();
      test_blanking();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Controller that time-shares one 7-segment decoder among NUM_DIGITS physical digits. It accepts a binary value on a load strobe and converts it to BCD sequentially using shift-add-3 (double dabble), one bit per cycle. It applies leading-zero blanking and continuously scans the digits. Its `digito` output drives the decoder's 4-bit input, and `anodos` selects the active digit.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DATA_W, 14, width of binary input; must satisfy 2^DATA_W > 10^NUM_DIGITS - 1
REFRESH_DIV, 50000, clock cycles each digit stays enabled (>= 1)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; capture `valor` when not busy
valor  in  DATA_W  unsigned binary value to display
busy  out  1  high while a conversion is in progress
overflow  out  1  last committed value exceeded 10^NUM_DIGITS - 1
digito  out  4  BCD nibble of the active digit; 4'hF = blank (decoder OFF code)
anodos  out  NUM_DIGITS  digit enables, active-low, one-cold

Behaviour:
- Reset (reset=1 at an edge):
  - Conversion FSM → IDLE; busy=0; overflow=0.
  - Display register = value 0; scan index=0; refresh counter=0.
  - Outputs after reset: anodos = ~1 (4'b1110 for 4 digits); digito = 4'h0.
  - Reset asserted mid-conversion aborts the conversion; the display reverts to 0.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE:
    - On load=1, capture `valor` into a shift register and clear the BCD accumulator (4*NUM_DIGITS bits).
    - Set overflow_pending = (valor > 10^NUM_DIGITS - 1).
    - Go to SHIFT with busy=1.
  - SHIFT, for exactly DATA_W cycles:
    - Each BCD nibble >= 5 gets +3.
    - Then {bcd, bin} shifts left by 1.
    - After DATA_W shifts, go to COMMIT.
  - COMMIT, 1 cycle:
    - Update the display register and overflow atomically from the accumulator and overflow_pending.
    - busy → 0; return to IDLE.
- Latency and handshake:
  - Load accepted at edge E0; busy=1 from E0 to E(DATA_W+1).
  - New digits are visible after E(DATA_W+1), i.e. DATA_W+1 cycles after acceptance.
  - load while busy=1 is ignored; no queueing.
  - load and reset in the same cycle: reset wins.
  - The display never shows partially converted digits.
- Blanking:
  - Digit k (k=0 is least significant) is blank (4'hF) if k > 0 and all nibbles k..NUM_DIGITS-1 are zero.
  - Digit 0 always shows its nibble, so value 0 displays "0".
  - Interior zeros are shown.
  - If overflow=1, all digits are blank.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 continuously, independent of conversion state.
  - On wrap, the scan index increments modulo NUM_DIGITS (NUM_DIGITS-1 → 0).
  - anodos = ~(1 << index).
  - digito = nibble[index], or 4'hF if that digit is blanked.
  - Both outputs are functions of registered state only; they change only on the edge where the index changes or the display register commits.
- Arithmetic: BCD accumulator is 4*NUM_DIGITS bits. For values above range, upper BCD bits are discarded; only the overflow flag matters in that case.

Test Plan:
(bench: NUM_DIGITS=4, DATA_W=14, REFRESH_DIV=4)
- Reset held 2 cycles, then released → busy=0, overflow=0, anodos=1110, digito=0; after 4 cycles anodos=1101, digito=F.
- load with valor=1234 → busy high for exactly 15 cycles. Scan then yields (anodos, digito) = (1110,4), (1101,3), (1011,2), (0111,1), 4 cycles each, then wraps to (1110,4).
- load 7 → digit0=7, digits1..3=F. Then load 1000 → digits = 0,0,0,1 (interior zeros shown). Then load 0 → digit0=0, others F.
- load 10000 → after commit overflow=1, all digits F. Then load 9999 → overflow=0, all digits 9.
- load 1234, then load 5678 on the 5th busy cycle → second load ignored; display shows 1234; busy falls at the original time.
- load 4321; after commit, load 56 and assert reset on the 8th busy cycle → busy=0 next cycle; display shows 0 (digit0=0, others F); anodos=1110.
